// File: rtl/execute_stage.sv
// MIPS execute stage: ALU-control decode, EX/MEM and MEM/WB forwarding, operand
// selection, a combinational ALU, and the EX/MEM pipeline register with stall/flush.
module execute_stage #(
  parameter int LEN      = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [1:0]          i_alu_op,
  input  logic [5:0]          i_funct,
  input  logic [5:0]          i_opcode,
  input  logic [4:0]          i_shamt,
  input  logic [LEN-1:0]      i_rs_data,
  input  logic [LEN-1:0]      i_rt_data,
  input  logic [LEN-1:0]      i_imm,
  input  logic                i_alu_src,
  input  logic [REG_ADDR-1:0] i_rs_addr,
  input  logic [REG_ADDR-1:0] i_rt_addr,
  input  logic [REG_ADDR-1:0] i_rd_addr,
  input  logic                i_reg_dst,
  input  logic                i_reg_write,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic                i_mem_to_reg,
  input  logic                i_wb_reg_write,
  input  logic [REG_ADDR-1:0] i_wb_rd,
  input  logic [LEN-1:0]      i_wb_data,
  output logic                o_valid,
  output logic [LEN-1:0]      o_alu_result,
  output logic [LEN-1:0]      o_store_data,
  output logic [REG_ADDR-1:0] o_dest_reg,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_mem_to_reg
);

  localparam int SHW = $clog2(LEN);

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_SRA  = 4'h2,
    ALU_ADD  = 4'h3,
    ALU_SUB  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_XOR  = 4'h7,
    ALU_NOR  = 4'h8,
    ALU_NONE = 4'hF
  } alu_code_e;

  function automatic logic [LEN-1:0] alu_f(input alu_code_e op,
                                           input logic [LEN-1:0] a,
                                           input logic [LEN-1:0] b);
    logic signed [LEN-1:0] b_s;
    b_s = b;
    case (op)
      ALU_SLL: alu_f = b << a[SHW-1:0];
      ALU_SRL: alu_f = b >> a[SHW-1:0];
      ALU_SRA: alu_f = b_s >>> a[SHW-1:0];
      ALU_ADD: alu_f = a + b;
      ALU_SUB: alu_f = a - b;
      ALU_AND: alu_f = a & b;
      ALU_OR:  alu_f = a | b;
      ALU_XOR: alu_f = a ^ b;
      ALU_NOR: alu_f = ~(a | b);
      default: alu_f = '0;
    endcase
  endfunction

  alu_code_e           alu_code;
  logic                use_zext, a_lui, a_shamt, a_rs_shift;
  logic                exm_fwd_ok, wb_fwd_ok;
  logic [LEN-1:0]      fwd_rs, fwd_rt, imm_ext, op_a, op_b, alu_res;

  logic                valid_q, valid_d;
  logic [LEN-1:0]      alu_result_q, alu_result_d;
  logic [LEN-1:0]      store_data_q, store_data_d;
  logic [REG_ADDR-1:0] dest_reg_q, dest_reg_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_to_reg_q, mem_to_reg_d;

  always_comb begin
    alu_code   = ALU_ADD;
    use_zext   = 1'b0;
    a_lui      = 1'b0;
    a_shamt    = 1'b0;
    a_rs_shift = 1'b0;
    case (i_alu_op)
      2'b00: alu_code = ALU_ADD;
      2'b01: alu_code = ALU_SUB;
      2'b10: begin
        case (i_funct)
          6'h00: begin alu_code = ALU_SLL; a_shamt    = 1'b1; end
          6'h02: begin alu_code = ALU_SRL; a_shamt    = 1'b1; end
          6'h03: begin alu_code = ALU_SRA; a_shamt    = 1'b1; end
          6'h04: begin alu_code = ALU_SLL; a_rs_shift = 1'b1; end
          6'h06: begin alu_code = ALU_SRL; a_rs_shift = 1'b1; end
          6'h07: begin alu_code = ALU_SRA; a_rs_shift = 1'b1; end
          6'h20, 6'h21: alu_code = ALU_ADD;
          6'h22, 6'h23: alu_code = ALU_SUB;
          6'h24: alu_code = ALU_AND;
          6'h25: alu_code = ALU_OR;
          6'h26: alu_code = ALU_XOR;
          6'h27: alu_code = ALU_NOR;
          default: alu_code = ALU_NONE;
        endcase
      end
      default: begin
        case (i_opcode)
          6'h0C: begin alu_code = ALU_AND; use_zext = 1'b1; end
          6'h0D: begin alu_code = ALU_OR;  use_zext = 1'b1; end
          6'h0E: begin alu_code = ALU_XOR; use_zext = 1'b1; end
          // lui is a left shift of the zero-extended immediate by 16
          6'h0F: begin alu_code = ALU_SLL; use_zext = 1'b1; a_lui = 1'b1; end
          default: alu_code = ALU_ADD;
        endcase
      end
    endcase
  end

  // Forwarding: EX/MEM (not a load) beats MEM/WB; $0 never forwards.
  always_comb begin
    exm_fwd_ok = valid_q & reg_write_q & ~mem_read_q & (dest_reg_q != '0);
    wb_fwd_ok  = i_wb_reg_write & (i_wb_rd != '0);
    if (exm_fwd_ok && dest_reg_q == i_rs_addr)   fwd_rs = alu_result_q;
    else if (wb_fwd_ok && i_wb_rd == i_rs_addr)  fwd_rs = i_wb_data;
    else                                         fwd_rs = i_rs_data;
    if (exm_fwd_ok && dest_reg_q == i_rt_addr)   fwd_rt = alu_result_q;
    else if (wb_fwd_ok && i_wb_rd == i_rt_addr)  fwd_rt = i_wb_data;
    else                                         fwd_rt = i_rt_data;
  end

  always_comb begin
    imm_ext = use_zext ? {{(LEN-16){1'b0}}, i_imm[15:0]} : i_imm;
    if (a_lui)           op_a = LEN'(16);
    else if (a_shamt)    op_a = {{(LEN-5){1'b0}}, i_shamt};
    else if (a_rs_shift) op_a = {{(LEN-5){1'b0}}, fwd_rs[4:0]};
    else                 op_a = fwd_rs;
    op_b    = i_alu_src ? imm_ext : fwd_rt;
    alu_res = alu_f(alu_code, op_a, op_b);
  end

  // EX/MEM register next state: flush or idle slot loads a bubble, stall holds.
  always_comb begin
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    dest_reg_d   = dest_reg_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (i_flush || (!i_stall && !i_valid)) begin
      valid_d      = 1'b0;
      alu_result_d = '0;
      store_data_d = '0;
      dest_reg_d   = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!i_stall) begin
      valid_d      = 1'b1;
      alu_result_d = alu_res;
      store_data_d = fwd_rt;
      dest_reg_d   = i_reg_dst ? i_rd_addr : i_rt_addr;
      reg_write_d  = i_reg_write;
      mem_read_d   = i_mem_read;
      mem_write_d  = i_mem_write;
      mem_to_reg_d = i_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      dest_reg_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      dest_reg_q   <= dest_reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_alu_result = alu_result_q;
  assign o_store_data = store_data_q;
  assign o_dest_reg   = dest_reg_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_read   = mem_read_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed cases plus randomized traffic
// checked against a behavioural model of the EX/MEM slot.
module tb_execute_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0;
  logic [1:0]  i_alu_op = '0;
  logic [5:0]  i_funct = '0, i_opcode = '0;
  logic [4:0]  i_shamt = '0;
  logic [31:0] i_rs_data = '0, i_rt_data = '0, i_imm = '0, i_wb_data = '0;
  logic        i_alu_src = 1'b0, i_reg_dst = 1'b0;
  logic [4:0]  i_rs_addr = '0, i_rt_addr = '0, i_rd_addr = '0, i_wb_rd = '0;
  logic        i_reg_write = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0, i_mem_to_reg = 1'b0;
  logic        i_wb_reg_write = 1'b0;
  logic        o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0]  o_dest_reg;

  execute_stage #(.LEN(32), .REG_ADDR(5)) dut (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_alu_op(i_alu_op), .i_funct(i_funct), .i_opcode(i_opcode), .i_shamt(i_shamt),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_alu_src(i_alu_src),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr), .i_reg_dst(i_reg_dst),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_to_reg(i_mem_to_reg), .i_wb_reg_write(i_wb_reg_write), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data), .o_valid(o_valid), .o_alu_result(o_alu_result),
    .o_store_data(o_store_data), .o_dest_reg(o_dest_reg), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic        rw, mr, mw, m2r;
  } exm_t;

  typedef struct {
    exm_t        e;
    bit          k_en;
    logic [31:0] k_res;
    logic        k_v;
    bit          k_sd_en;
    logic [31:0] k_sd;
    int          id;
  } sb_t;

  sb_t  sbq[$];
  sb_t  s_mon;
  exm_t m = '0;
  exm_t act;
  int   errors = 0, checks = 0;
  bit   k_en, k_sd_en;
  logic [31:0] k_res, k_sd;
  logic k_v;
  int   k_id;

  assign act = {o_valid, o_alu_result, o_store_data, o_dest_reg,
                o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg};

  // Reference model: value seen for a register after forwarding.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (m.v && m.rw && !m.mr && m.dst != 5'd0 && m.dst == a) return m.res;
    if (i_wb_reg_write && i_wb_rd != 5'd0 && i_wb_rd == a) return i_wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] a, rt, b, zb;
    logic signed [31:0] sb;
    a  = fwd(i_rs_addr, i_rs_data);
    rt = fwd(i_rt_addr, i_rt_data);
    b  = i_alu_src ? i_imm : rt;
    zb = i_alu_src ? {16'h0, i_imm[15:0]} : rt;
    sb = b;
    case (i_alu_op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        case (i_funct)
          6'h00: return b << i_shamt;
          6'h04: return b << a[4:0];
          6'h02: return b >> i_shamt;
          6'h06: return b >> a[4:0];
          6'h03: return sb >>> i_shamt;
          6'h07: return sb >>> a[4:0];
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          default: return 32'h0;
        endcase
      end
      default: begin
        case (i_opcode)
          6'h0C: return a & zb;
          6'h0D: return a | zb;
          6'h0E: return a ^ zb;
          6'h0F: return zb << 16;
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  function automatic exm_t model_next();
    exm_t n;
    n = '0;
    if (reset || i_flush) return n;
    if (i_stall) return m;
    if (!i_valid) return n;
    n.v   = 1'b1;
    n.res = model_result();
    n.sd  = fwd(i_rt_addr, i_rt_data);
    n.dst = i_reg_dst ? i_rd_addr : i_rt_addr;
    n.rw  = i_reg_write;
    n.mr  = i_mem_read;
    n.mw  = i_mem_write;
    n.m2r = i_mem_to_reg;
    return n;
  endfunction

  // Wait for the falling edge and park every input at an idle value.
  task automatic nop();
    @(negedge clk);
    reset = 0; i_stall = 0; i_flush = 0; i_valid = 0;
    i_alu_op = 0; i_funct = 0; i_opcode = 0; i_shamt = 0;
    i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_alu_src = 0;
    i_rs_addr = 0; i_rt_addr = 0; i_rd_addr = 0; i_reg_dst = 0;
    i_reg_write = 0; i_mem_read = 0; i_mem_write = 0; i_mem_to_reg = 0;
    i_wb_reg_write = 0; i_wb_rd = 0; i_wb_data = 0;
    k_en = 0; k_sd_en = 0; k_res = 0; k_sd = 0; k_v = 0; k_id = 0;
  endtask

  task automatic commit();
    sb_t s;
    exm_t n;
    n = model_next();
    s.e = n; s.k_en = k_en; s.k_res = k_res; s.k_v = k_v;
    s.k_sd_en = k_sd_en; s.k_sd = k_sd; s.id = k_id;
    sbq.push_back(s);
    m = n;
  endtask

  task automatic alu_instr(input logic [1:0] op, input logic [5:0] fn, input logic [5:0] opc,
                           input logic [4:0] rsa, input logic [31:0] rsd,
                           input logic [4:0] rta, input logic [31:0] rtd,
                           input logic [31:0] imm, input logic src, input logic [4:0] dst);
    i_valid = 1; i_alu_op = op; i_funct = fn; i_opcode = opc;
    i_rs_addr = rsa; i_rs_data = rsd; i_rt_addr = rta; i_rt_data = rtd;
    i_imm = imm; i_alu_src = src; i_reg_dst = 1; i_rd_addr = dst; i_reg_write = 1;
  endtask

  task automatic expect_k(input int id, input logic [31:0] r, input logic v);
    k_en = 1; k_id = id; k_res = r; k_v = v;
  endtask

  function automatic logic [5:0] pick_funct(input int i);
    case (i)
      0: return 6'h00;  1: return 6'h04;  2: return 6'h02;  3: return 6'h06;
      4: return 6'h03;  5: return 6'h07;  6: return 6'h20;  7: return 6'h21;
      8: return 6'h22;  9: return 6'h23; 10: return 6'h24; 11: return 6'h25;
      12: return 6'h26; 13: return 6'h27; 14: return 6'h2A;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_opc(input int i);
    case (i)
      0: return 6'h08; 1: return 6'h09; 2: return 6'h0C;
      3: return 6'h0D; 4: return 6'h0E; 5: return 6'h0F;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rdata();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 63));
      1: return 32'h8000_0000 | $urandom;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_fields();
    i_alu_op = 2'($urandom); i_funct = pick_funct($urandom_range(0, 16));
    i_opcode = pick_opc($urandom_range(0, 7)); i_shamt = 5'($urandom);
    i_rs_data = rdata(); i_rt_data = rdata(); i_imm = rdata();
    i_alu_src = (i_alu_op == 2'd3) ? 1'b1 : 1'($urandom);
    i_rs_addr = 5'($urandom_range(0, 7)); i_rt_addr = 5'($urandom_range(0, 7));
    i_rd_addr = 5'($urandom_range(0, 7)); i_reg_dst = 1'($urandom);
    i_reg_write = 1'($urandom); i_mem_read = ($urandom_range(0, 3) == 0);
    i_mem_write = 1'($urandom); i_mem_to_reg = 1'($urandom);
    i_wb_reg_write = 1'($urandom); i_wb_rd = 5'($urandom_range(0, 7)); i_wb_data = rdata();
  endtask

  // Monitor: pops one expectation per presented EX/MEM slot.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        s_mon = sbq.pop_front();
        checks++;
        if (act !== s_mon.e) begin
          errors++;
          $display("FAIL exmem t=%0t got v=%b res=%h sd=%h dst=%0d ctl=%b%b%b%b want v=%b res=%h sd=%h dst=%0d ctl=%b%b%b%b",
                   $time, act.v, act.res, act.sd, act.dst, act.rw, act.mr, act.mw, act.m2r,
                   s_mon.e.v, s_mon.e.res, s_mon.e.sd, s_mon.e.dst,
                   s_mon.e.rw, s_mon.e.mr, s_mon.e.mw, s_mon.e.m2r);
        end
        if (s_mon.k_en) begin
          checks++;
          if (o_alu_result !== s_mon.k_res || o_valid !== s_mon.k_v) begin
            errors++;
            $display("FAIL plan%0d got res=%h v=%b want res=%h v=%b",
                     s_mon.id, o_alu_result, o_valid, s_mon.k_res, s_mon.k_v);
          end
        end
        if (s_mon.k_sd_en) begin
          checks++;
          if (o_store_data !== s_mon.k_sd || o_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL store%0d got sd=%h mw=%b want sd=%h mw=1",
                     s_mon.id, o_store_data, o_mem_write, s_mon.k_sd);
          end
        end
      end
    end
  end

  initial begin
    // Reset held two cycles with live-looking inputs
    for (int i = 0; i < 2; i++) begin
      nop(); rand_fields(); i_valid = 1; reset = 1; expect_k(10 + i, 32'h0, 1'b0); commit();
    end
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd5, 5'd2, 32'd7, 0, 0, 5'd3);
    expect_k(12, 32'd12, 1); commit();

    // R-type coverage
    nop(); alu_instr(2'd2, 6'h03, 6'h0, 5'd21, 0, 5'd22, 32'h8000_0000, 0, 0, 5'd20);
    i_shamt = 5'd4; expect_k(20, 32'hF800_0000, 1); commit();
    nop(); alu_instr(2'd2, 6'h06, 6'h0, 5'd21, 32'h24, 5'd22, 32'h8000_0000, 0, 0, 5'd20);
    expect_k(21, 32'h0800_0000, 1); commit();
    nop(); alu_instr(2'd2, 6'h27, 6'h0, 5'd21, 0, 5'd22, 0, 0, 0, 5'd20);
    expect_k(22, 32'hFFFF_FFFF, 1); commit();
    nop(); alu_instr(2'd2, 6'h2A, 6'h0, 5'd21, 32'd9, 5'd22, 32'd4, 0, 0, 5'd20);
    expect_k(23, 32'h0, 1); commit();

    // Immediates
    nop(); alu_instr(2'd3, 6'h0, 6'h0D, 5'd21, 32'h0000_F000, 5'd22, 0, 32'hFFFF_8001, 1, 5'd20);
    expect_k(30, 32'h0000_F001, 1); commit();
    nop(); alu_instr(2'd3, 6'h0, 6'h08, 5'd21, 32'd1, 5'd22, 0, 32'hFFFF_FFFF, 1, 5'd20);
    expect_k(31, 32'h0, 1); commit();
    nop(); alu_instr(2'd3, 6'h0, 6'h0F, 5'd21, 32'd77, 5'd22, 0, 32'h0000_1234, 1, 5'd20);
    expect_k(32, 32'h1234_0000, 1); commit();

    // Forwarding
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd1, 5'd2, 32'd2, 0, 0, 5'd3);
    expect_k(40, 32'd3, 1); commit();
    nop(); alu_instr(2'd1, 6'h0, 6'h0, 5'd3, 32'd99, 5'd3, 32'd99, 0, 0, 5'd4);
    expect_k(41, 32'd0, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd1, 5'd2, 32'd2, 0, 0, 5'd3);
    expect_k(42, 32'd3, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd3, 32'd99, 5'd1, 32'd10, 0, 0, 5'd6);
    expect_k(43, 32'd13, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd1, 5'd2, 32'd2, 0, 0, 5'd3);
    expect_k(44, 32'd3, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd3, 32'd99, 5'd0, 32'd0, 0, 0, 5'd6);
    i_wb_reg_write = 1; i_wb_rd = 5'd3; i_wb_data = 32'd500;
    expect_k(45, 32'd3, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd1, 5'd2, 32'd2, 0, 0, 5'd0);
    expect_k(46, 32'd3, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 5'd8);
    i_wb_reg_write = 1; i_wb_rd = 5'd0; i_wb_data = 32'd77;
    expect_k(47, 32'd0, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'h200, 5'd3, 0, 32'd4, 1, 5'd0);
    i_reg_dst = 0; i_mem_read = 1; i_mem_to_reg = 1;
    expect_k(48, 32'h204, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd3, 32'd40, 5'd2, 32'd2, 0, 0, 5'd7);
    i_wb_reg_write = 1; i_wb_rd = 5'd3; i_wb_data = 32'd1000;
    expect_k(49, 32'd1002, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'h200, 5'd3, 0, 32'd4, 1, 5'd0);
    i_reg_dst = 0; i_mem_read = 1; i_mem_to_reg = 1;
    expect_k(50, 32'h204, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd3, 32'd40, 5'd2, 32'd2, 0, 0, 5'd7);
    expect_k(51, 32'd42, 1); commit();

    // Stall, flush, idle slot
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd10, 5'd2, 32'd20, 0, 0, 5'd5);
    expect_k(60, 32'd30, 1); commit();
    for (int i = 0; i < 3; i++) begin
      nop(); alu_instr(2'd1, 6'h0, 6'h0, 5'd5, 32'd1000, 5'd2, 32'd1, 0, 0, 5'd9);
      i_stall = 1; expect_k(61 + i, 32'd30, 1); commit();
    end
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd5, 32'd0, 5'd0, 32'd0, 0, 0, 5'd9);
    expect_k(64, 32'd30, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd3, 5'd2, 32'd4, 0, 0, 5'd9);
    i_stall = 1; i_flush = 1; expect_k(65, 32'd0, 0); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd3, 5'd2, 32'd4, 0, 0, 5'd9);
    expect_k(66, 32'd7, 1); commit();
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'd3, 5'd2, 32'd4, 0, 0, 5'd9);
    i_valid = 0; expect_k(67, 32'd0, 0); commit();

    // Store with rt forwarded from MEM/WB
    nop(); alu_instr(2'd0, 6'h0, 6'h0, 5'd1, 32'h100, 5'd9, 32'd0, 32'd8, 1, 5'd0);
    i_reg_write = 0; i_mem_write = 1;
    i_wb_reg_write = 1; i_wb_rd = 5'd9; i_wb_data = 32'hDEAD_BEEF;
    expect_k(70, 32'h108, 1); k_sd_en = 1; k_sd = 32'hDEAD_BEEF; commit();

    // Randomized traffic, including occasional mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      nop(); rand_fields();
      reset   = ($urandom_range(0, 99) == 0);
      i_stall = ($urandom_range(0, 7) == 0);
      i_flush = ($urandom_range(0, 15) == 0);
      i_valid = ($urandom_range(0, 7) != 0);
      commit();
    end
    nop(); commit();

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got pending=%0d want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage MIPS pipeline. It sits between the ID/EX fields and the EX/MEM pipeline register. It decodes ALU control, resolves data forwarding, selects the operands and drives the team's 32-bit combinational `alu` (4-bit OPCODE, operands A/B), then registers the result and the pass-through control into EX/MEM. It supports stall (hold) and flush (bubble).

## Interface
- `LEN`, 32, datapath width
- `REG_ADDR`, 5, register-address width
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `i_stall` in 1: hold EX/MEM contents
- `i_flush` in 1: load a bubble
- `i_valid` in 1: ID/EX slot holds a real instruction
- `i_alu_op` in 2: 00 add, 01 sub, 10 R-type (use funct), 11 I-type (use opcode)
- `i_funct` in 6: R-type function field
- `i_opcode` in 6: instruction opcode
- `i_shamt` in 5: shift amount
- `i_rs_data` in LEN: register-file read of rs
- `i_rt_data` in LEN: register-file read of rt
- `i_imm` in LEN: sign-extended immediate
- `i_alu_src` in 1: B operand select, 0 = rt, 1 = immediate
- `i_rs_addr` in REG_ADDR: rs index, used for forwarding
- `i_rt_addr` in REG_ADDR: rt index
- `i_rd_addr` in REG_ADDR: rd index
- `i_reg_dst` in 1: destination select, 1 = rd, 0 = rt
- `i_reg_write`, `i_mem_read`, `i_mem_write`, `i_mem_to_reg` in 1 each: control passed through to EX/MEM
- `i_wb_reg_write` in 1: MEM/WB write enable
- `i_wb_rd` in REG_ADDR: MEM/WB destination
- `i_wb_data` in LEN: MEM/WB write-back value
- `o_valid` out 1: EX/MEM slot holds a real instruction
- `o_alu_result` out LEN: registered ALU result
- `o_store_data` out LEN: forwarded rt value, used by sw
- `o_dest_reg` out REG_ADDR: registered destination index
- `o_reg_write`, `o_mem_read`, `o_mem_write`, `o_mem_to_reg` out 1 each: registered control

## Operation
**ALU opcode encoding**
- 0000 sll, 0001 srl, 0010 sra, 0011 add, 0100 sub, 0101 and, 0110 or, 0111 xor, 1000 nor.
- Any other code gives result 0.

**Opcode selection**
- `i_alu_op`=00 selects 0011 (add); 01 selects 0100 (sub).
- `i_alu_op`=10 decodes funct:
  - 0x00/0x04 → 0000; 0x02/0x06 → 0001; 0x03/0x07 → 0010.
  - 0x20/0x21 → 0011; 0x22/0x23 → 0100.
  - 0x24 → 0101; 0x25 → 0110; 0x26 → 0111; 0x27 → 1000.
  - Any other funct → 1111 (result 0; control still passes through).
- `i_alu_op`=11 decodes opcode:
  - 0x08/0x09 → add, sign-extended immediate.
  - 0x0C/0x0D/0x0E → and/or/xor, zero-extended `{16'b0, i_imm[15:0]}`.
  - 0x0F (lui) → 0000 with A=16 and B=`{16'b0, i_imm[15:0]}`.
  - Any other opcode → add.

**Forwarding** (resolved separately for rs and rt)
- Source 1: EX/MEM, when `o_valid & o_reg_write & !o_mem_read & o_dest_reg!=0 & o_dest_reg==addr`. Data is `o_alu_result`.
- Source 2, otherwise: MEM/WB, when `i_wb_reg_write & i_wb_rd!=0 & i_wb_rd==addr`. Data is `i_wb_data`.
- Otherwise the register-file value is used.
- EX/MEM takes priority over MEM/WB.

**Operand selection**
- Fixed shifts (funct 0x00/02/03): A=`{27'b0, i_shamt}`.
- Variable shifts (0x04/06/07): A=`{27'b0, fwd_rs[4:0]}`.
- All other operations: A=fwd_rs.
- B = `i_alu_src` ? immediate (as extended above) : fwd_rt.

**Register outputs**
- `o_store_data` = fwd_rt.
- `o_dest_reg` = `i_reg_dst` ? rd : rt.

## Timing
- Latency is 1 cycle. Inputs are sampled on the rising edge; EX/MEM outputs update at that edge.
- Update priority per edge:
  - `reset` sets every output to 0.
  - else `i_flush` (bubble: `o_valid` and all control 0, data 0).
  - else `i_stall` (all outputs hold).
  - else `!i_valid` (bubble).
  - else load.
- Flush together with stall produces a bubble.
- During a stall, forwarding keeps using the held EX/MEM value.
- Forwarding is combinational within the cycle. There is no internal state other than the EX/MEM register.
- A reset asserted mid-stream discards the in-flight instruction. The first load after reset deassertion is normal.

## Test plan
1. **Reset.** Hold `reset` for 2 cycles with arbitrary inputs → all outputs 0. Release, then apply add rs=5, rt=7 → next cycle `o_alu_result`=12, `o_valid`=1.
2. **R-type coverage.**
   - sra with rt=0x80000000, shamt=4 → 0xF8000000.
   - srlv with rs=0x24 (shift 4), same rt → 0x08000000.
   - nor 0,0 → 0xFFFFFFFF.
   - funct 0x2A → result 0.
3. **Immediates.**
   - ori rs=0x0000F000, imm=0xFFFF8001 → 0x0000F001.
   - addi rs=1, imm=0xFFFFFFFF → 0.
   - lui imm=0x1234 → 0x12340000.
4. **Forwarding.**
   - add $3=1+2, then sub $4=$3-$3 with stale register-file data 99 → 0.
   - MEM/WB and EX/MEM both target $3 → EX/MEM value wins.
   - Destination $0 → no forward.
   - EX/MEM holding lw to $3 → MEM/WB or register-file value used.
5. **Stall/flush.**
   - Stall for 3 cycles → outputs frozen.
   - Flush+stall together → `o_valid`=0, `o_reg_write`=0.
   - `i_valid`=0 → bubble.
6. **Store path.** sw with rt forwarded from MEM/WB (0xDEADBEEF), base 0x100, imm 8 → `o_alu_result`=0x108, `o_store_data`=0xDEADBEEF, `o_mem_write`=1.
